// File: rtl/vad_decision_smoother_if.sv
// Bus bundle for the VAD decision smoother.
// master: drives flush / frame_valid / result_in and observes the smoothed outputs.
// slave : the smoother itself.
// Signals:
//   flush        - synchronous clear to SILENCE, beats frame_valid
//   frame_valid  - one-cycle strobe, result_in is a fresh decision
//   result_in    - comparator class code (10 speech, 01 non-speech, else no result)
//   vad_out      - smoothed decision
//   vad_valid    - vad_out updated for an accepted frame
//   onset_pulse  - entry to SPEECH
//   offset_pulse - release to SILENCE
//   state_o      - FSM state (0 SILENCE, 1 ONSET_PEND, 2 SPEECH, 3 HANGOVER)
//   speech_cnt   - saturating count of frames with vad_out=1
interface vad_decision_smoother_if #(
  parameter int STAT_W = 16
);
  logic              flush;
  logic              frame_valid;
  logic [1:0]        result_in;
  logic              vad_out;
  logic              vad_valid;
  logic              onset_pulse;
  logic              offset_pulse;
  logic [1:0]        state_o;
  logic [STAT_W-1:0] speech_cnt;

  modport master (
    output flush, frame_valid, result_in,
    input  vad_out, vad_valid, onset_pulse, offset_pulse, state_o, speech_cnt
  );

  modport slave (
    input  flush, frame_valid, result_in,
    output vad_out, vad_valid, onset_pulse, offset_pulse, state_o, speech_cnt
  );
endinterface

// File: rtl/vad_decision_smoother.sv
// VAD decision smoother: onset debounce plus hangover on the per-frame
// speech / non-speech decision coming out of the final score comparator.
// Ports:
//   clk  - rising-edge clock
//   rst  - asynchronous active-high reset
//   bus  - slave side of vad_decision_smoother_if (frame input, smoothed
//          flag, event pulses, state and saturating speech-frame count)
// Every output is registered; a frame accepted on cycle N is reflected on N+1.
module vad_decision_smoother #(
  parameter int ONSET_FRAMES = 3,
  parameter int HANG_FRAMES  = 8,
  parameter int CNT_W        = 4,
  parameter int STAT_W       = 16
) (
  input logic                     clk,
  input logic                     rst,
  vad_decision_smoother_if.slave  bus
);

  typedef enum logic [1:0] {
    SILENCE    = 2'd0,
    ONSET_PEND = 2'd1,
    SPEECH     = 2'd2,
    HANGOVER   = 2'd3
  } state_t;

  localparam logic [CNT_W-1:0]  ONSET_C  = CNT_W'(ONSET_FRAMES);
  localparam logic [CNT_W-1:0]  HANG_C   = CNT_W'(HANG_FRAMES);
  localparam logic [CNT_W-1:0]  CNT_ONE  = CNT_W'(1);
  localparam logic [STAT_W-1:0] STAT_MAX = {STAT_W{1'b1}};

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              vad_q, vad_d;
  logic              vld_q, vld_d;
  logic              onset_q, onset_d;
  logic              offset_q, offset_d;
  logic [STAT_W-1:0] stat_q, stat_d;

  logic              is_s;
  logic              is_n;
  logic [CNT_W-1:0]  cnt_inc;

  assign is_s    = (bus.result_in == 2'b10);
  assign is_n    = (bus.result_in == 2'b01);
  assign cnt_inc = cnt_q + CNT_ONE;

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    vad_d    = vad_q;
    vld_d    = 1'b0;
    onset_d  = 1'b0;
    offset_d = 1'b0;
    stat_d   = stat_q;

    if (bus.flush) begin
      // Flush drops any coincident frame and leaves the statistics alone.
      state_d = SILENCE;
      cnt_d   = '0;
      vad_d   = 1'b0;
    end else if (bus.frame_valid) begin
      vld_d = 1'b1;
      // No-result frames (neither is_s nor is_n) fall through every branch
      // and hold state and counter.
      unique case (state_q)
        SILENCE: begin
          if (is_s) begin
            if (ONSET_FRAMES == 1) begin
              state_d = SPEECH;
              cnt_d   = '0;
              onset_d = 1'b1;
            end else begin
              state_d = ONSET_PEND;
              cnt_d   = CNT_ONE;
            end
          end
        end
        ONSET_PEND: begin
          if (is_s) begin
            if (cnt_inc == ONSET_C) begin
              state_d = SPEECH;
              cnt_d   = '0;
              onset_d = 1'b1;
            end else begin
              cnt_d = cnt_inc;
            end
          end else if (is_n) begin
            state_d = SILENCE;
            cnt_d   = '0;
          end
        end
        SPEECH: begin
          if (is_n) begin
            // A hangover of 0 or 1 frame releases on the first non-speech frame.
            if (HANG_FRAMES <= 1) begin
              state_d  = SILENCE;
              cnt_d    = '0;
              offset_d = 1'b1;
            end else begin
              state_d = HANGOVER;
              cnt_d   = CNT_ONE;
            end
          end
        end
        HANGOVER: begin
          if (is_s) begin
            state_d = SPEECH;
            cnt_d   = '0;
          end else if (is_n) begin
            if (cnt_inc == HANG_C) begin
              state_d  = SILENCE;
              cnt_d    = '0;
              offset_d = 1'b1;
            end else begin
              cnt_d = cnt_inc;
            end
          end
        end
        default: begin
          state_d = SILENCE;
          cnt_d   = '0;
        end
      endcase

      vad_d = (state_d == SPEECH) || (state_d == HANGOVER);
      if (vad_d && (stat_q != STAT_MAX)) begin
        stat_d = stat_q + STAT_W'(1);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= SILENCE;
      cnt_q    <= '0;
      vad_q    <= 1'b0;
      vld_q    <= 1'b0;
      onset_q  <= 1'b0;
      offset_q <= 1'b0;
      stat_q   <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      vad_q    <= vad_d;
      vld_q    <= vld_d;
      onset_q  <= onset_d;
      offset_q <= offset_d;
      stat_q   <= stat_d;
    end
  end

  assign bus.vad_out      = vad_q;
  assign bus.vad_valid    = vld_q;
  assign bus.onset_pulse  = onset_q;
  assign bus.offset_pulse = offset_q;
  assign bus.state_o      = state_q;
  assign bus.speech_cnt   = stat_q;

endmodule

// File: tb/tb_vad_decision_smoother.sv
module tb_vad_decision_smoother;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  // Instance 0: default parameters. Instance 1: immediate onset, no hangover,
  // narrow statistics counter so saturation is reachable quickly.
  vad_decision_smoother_if #(.STAT_W(16)) if0 ();
  vad_decision_smoother_if #(.STAT_W(4))  if1 ();

  vad_decision_smoother #(.ONSET_FRAMES(3), .HANG_FRAMES(8), .CNT_W(4), .STAT_W(16))
    dut0 (.clk(clk), .rst(rst), .bus(if0.slave));
  vad_decision_smoother #(.ONSET_FRAMES(1), .HANG_FRAMES(0), .CNT_W(4), .STAT_W(4))
    dut1 (.clk(clk), .rst(rst), .bus(if1.slave));

  localparam logic [1:0] S = 2'b10;
  localparam logic [1:0] N = 2'b01;
  localparam logic [1:0] X = 2'b00;

  int checks   = 0;
  int failures = 0;

  // Reference model: a speech flag plus a run length of frames that argue
  // against the current flag. The run length reaching the onset / hangover
  // threshold flips the flag.
  int onset_th [2] = '{3, 1};
  int hang_th  [2] = '{8, 0};
  int stat_max [2] = '{65535, 15};
  bit m_vad [2];
  int m_run [2];
  int m_stat[2];
  bit e_vld [2];
  bit e_on  [2];
  bit e_off [2];

  function automatic int model_state(input int k);
    if (!m_vad[k]) return (m_run[k] == 0) ? 0 : 1;
    return (m_run[k] == 0) ? 2 : 3;
  endfunction

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      m_vad[k] = 0; m_run[k] = 0; m_stat[k] = 0;
      e_vld[k] = 0; e_on[k] = 0; e_off[k] = 0;
    end
  endtask

  task automatic model_step(input bit f, input bit v, input logic [1:0] r);
    for (int k = 0; k < 2; k++) begin
      e_vld[k] = 0; e_on[k] = 0; e_off[k] = 0;
      if (f) begin
        m_vad[k] = 0;
        m_run[k] = 0;
      end else if (v) begin
        e_vld[k] = 1;
        if (r == S) begin
          if (!m_vad[k]) begin
            m_run[k]++;
            if (m_run[k] >= onset_th[k]) begin
              m_vad[k] = 1; m_run[k] = 0; e_on[k] = 1;
            end
          end else begin
            m_run[k] = 0;
          end
        end else if (r == N) begin
          if (m_vad[k]) begin
            m_run[k]++;
            if (m_run[k] >= hang_th[k]) begin
              m_vad[k] = 0; m_run[k] = 0; e_off[k] = 1;
            end
          end else begin
            m_run[k] = 0;
          end
        end
        if (m_vad[k] && m_stat[k] < stat_max[k]) m_stat[k]++;
      end
    end
  endtask

  task automatic chk(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string ph);
    chk({ph, ".vad0"},   int'(if0.vad_out),      int'(m_vad[0]));
    chk({ph, ".vld0"},   int'(if0.vad_valid),    int'(e_vld[0]));
    chk({ph, ".on0"},    int'(if0.onset_pulse),  int'(e_on[0]));
    chk({ph, ".off0"},   int'(if0.offset_pulse), int'(e_off[0]));
    chk({ph, ".st0"},    int'(if0.state_o),      model_state(0));
    chk({ph, ".cnt0"},   int'(if0.speech_cnt),   m_stat[0]);
    chk({ph, ".vad1"},   int'(if1.vad_out),      int'(m_vad[1]));
    chk({ph, ".vld1"},   int'(if1.vad_valid),    int'(e_vld[1]));
    chk({ph, ".on1"},    int'(if1.onset_pulse),  int'(e_on[1]));
    chk({ph, ".off1"},   int'(if1.offset_pulse), int'(e_off[1]));
    chk({ph, ".st1"},    int'(if1.state_o),      model_state(1));
    chk({ph, ".cnt1"},   int'(if1.speech_cnt),   m_stat[1]);
  endtask

  task automatic drive(input bit f, input bit v, input logic [1:0] r);
    if0.flush = f; if0.frame_valid = v; if0.result_in = r;
    if1.flush = f; if1.frame_valid = v; if1.result_in = r;
  endtask

  // Called at a falling edge: present inputs, let one rising edge pass,
  // then compare at the next falling edge.
  task automatic apply(input string ph, input bit f, input bit v, input logic [1:0] r);
    drive(f, v, r);
    model_step(f, v, r);
    @(negedge clk);
    check_all(ph);
    drive(1'b0, 1'b0, X);
  endtask

  task automatic frames(input string ph, input logic [1:0] r, input int n);
    for (int i = 0; i < n; i++) apply(ph, 1'b0, 1'b1, r);
  endtask

  int base_cnt;
  logic [1:0] cls;
  bit rf, rv;

  initial begin
    drive(1'b0, 1'b0, X);
    model_reset();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    check_all("reset");
    rst = 1'b0;
    apply("idle", 1'b0, 1'b0, X);

    // Onset after three speech frames
    apply("t1a", 1'b0, 1'b1, S);
    chk("t1a.state", int'(if0.state_o), 1);
    apply("t1b", 1'b0, 1'b1, S);
    chk("t1b.state", int'(if0.state_o), 1);
    apply("t1c", 1'b0, 1'b1, S);
    chk("t1c.state", int'(if0.state_o), 2);
    chk("t1c.onset", int'(if0.onset_pulse), 1);
    chk("t1c.cnt",   int'(if0.speech_cnt), 1);

    // Hangover bridges seven non-speech frames
    base_cnt = int'(if0.speech_cnt);
    frames("t2n", N, 7);
    chk("t2.hang_state", int'(if0.state_o), 3);
    apply("t2s", 1'b0, 1'b1, S);
    chk("t2.state", int'(if0.state_o), 2);
    chk("t2.cnt",   int'(if0.speech_cnt), base_cnt + 8);

    // Eight non-speech frames release
    frames("t3n", N, 7);
    chk("t3.pre_vad", int'(if0.vad_out), 1);
    apply("t3last", 1'b0, 1'b1, N);
    chk("t3.vad", int'(if0.vad_out), 0);
    chk("t3.off", int'(if0.offset_pulse), 1);
    apply("t3after", 1'b0, 1'b0, X);
    chk("t3.off_clear", int'(if0.offset_pulse), 0);

    // Aborted onset with interleaved no-result frames
    apply("t4", 1'b0, 1'b1, S);
    apply("t4", 1'b0, 1'b1, X);
    apply("t4", 1'b0, 1'b1, S);
    chk("t4.pend", int'(if0.state_o), 1);
    apply("t4", 1'b0, 1'b1, N);
    chk("t4.abort", int'(if0.state_o), 0);
    apply("t4", 1'b0, 1'b1, S);
    apply("t4", 1'b0, 1'b1, 2'b11);
    apply("t4", 1'b0, 1'b1, S);
    apply("t4", 1'b0, 1'b1, X);
    chk("t4.hold", int'(if0.state_o), 1);
    apply("t4", 1'b0, 1'b1, S);
    chk("t4.onset", int'(if0.onset_pulse), 1);

    // Flush in HANGOVER with four non-speech frames counted
    frames("t5n", N, 4);
    chk("t5.hang", int'(if0.state_o), 3);
    base_cnt = int'(if0.speech_cnt);
    apply("t5flush", 1'b1, 1'b1, S);
    chk("t5.state", int'(if0.state_o), 0);
    chk("t5.vld",   int'(if0.vad_valid), 0);
    chk("t5.cnt",   int'(if0.speech_cnt), base_cnt);

    // Immediate onset / no hangover instance: S,N,S,N, then saturation
    apply("t6r", 1'b0, 1'b0, X);
    rst = 1'b1;
    #1;
    model_reset();
    check_all("t6rst");
    rst = 1'b0;
    apply("t6a", 1'b0, 1'b1, S);
    chk("t6a.on", int'(if1.onset_pulse), 1);
    apply("t6b", 1'b0, 1'b1, N);
    chk("t6b.off", int'(if1.offset_pulse), 1);
    apply("t6c", 1'b0, 1'b1, S);
    apply("t6d", 1'b0, 1'b1, N);
    chk("t6.cnt", int'(if1.speech_cnt), 2);
    frames("t6sat", S, 16);
    chk("t6.sat", int'(if1.speech_cnt), 15);

    // Asynchronous reset between edges discards a pending run
    apply("t7", 1'b0, 1'b1, N);
    apply("t7", 1'b0, 1'b1, S);
    #2 rst = 1'b1;
    #1;
    model_reset();
    check_all("t7rst");
    #1 rst = 1'b0;
    @(negedge clk);
    check_all("t7post");

    // Randomized traffic with sticky classes so long runs occur
    cls = S;
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 99) < 20) begin
        case ($urandom_range(0, 5))
          0, 1, 2: cls = S;
          3, 4:    cls = N;
          default: cls = 2'($urandom_range(0, 1) * 3);
        endcase
      end
      rf = ($urandom_range(0, 49) == 0);
      rv = ($urandom_range(0, 9) < 8);
      apply("rand", rf, rv, cls);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "simulation time limit");
  end

endmodule

// File: doc/vad_decision_smoother.md
Name: vad_decision_smoother

Overview:
- Sits directly downstream of the final 1x2 score comparator in the BNN-VAD datapath.
- Consumes the per-frame 2-bit class decision (10 = speech/class 1, 01 = non-speech/class 2, 00 = no result) plus a one-cycle strobe marking a fresh decision.
- Applies onset debouncing and hangover so the exported VAD flag does not chatter frame to frame.
- Emits a smoothed VAD flag, onset/offset event pulses and a saturating speech-frame count.

Parameters:
- ONSET_FRAMES, 3: consecutive speech frames required to declare speech; legal range 1..2^CNT_W-1.
- HANG_FRAMES, 8: consecutive non-speech frames required to release speech; legal range 0..2^CNT_W-1.
- CNT_W, 4: width of the internal run counter.
- STAT_W, 16: width of the speech-frame statistics counter.

Ports:
- clk, input, 1: system clock, rising edge.
- rst, input, 1: asynchronous, active-high reset.
- flush, input, 1: synchronous clear to SILENCE; has priority over frame_valid.
- frame_valid, input, 1: one-cycle strobe; result_in is fresh this cycle.
- result_in, input, 2: comparator class code; 10 = speech, 01 = non-speech, 00/11 = no result.
- vad_out, output, 1: smoothed decision; 1 in SPEECH or HANGOVER.
- vad_valid, output, 1: one-cycle pulse; vad_out updated for a frame.
- onset_pulse, output, 1: one-cycle pulse on entry to SPEECH from SILENCE or ONSET_PEND.
- offset_pulse, output, 1: one-cycle pulse on release to SILENCE from SPEECH or HANGOVER.
- state_o, output, 2: current FSM state; 0 SILENCE, 1 ONSET_PEND, 2 SPEECH, 3 HANGOVER.
- speech_cnt, output, STAT_W: number of frames with updated vad_out=1; saturates at all-ones.

Behaviour:
- Reset (rst=1, asynchronous):
  - State SILENCE, run counter 0, speech_cnt 0.
  - vad_out, vad_valid, onset_pulse and offset_pulse all 0.
  - Reset mid-frame discards any pending run.
- Latency and output registration:
  - All outputs are registered.
  - A frame accepted on cycle N updates state, vad_out, pulses and speech_cnt visible on cycle N+1.
  - vad_valid pulses on N+1 for every accepted frame, including no-result frames.
  - vad_valid, onset_pulse and offset_pulse are 0 on all other cycles.
- Frame classes (only sampled when frame_valid=1):
  - S = speech (10).
  - N = non-speech (01).
  - X = no result (00/11). An X frame holds state and counter; vad_valid still pulses with the unchanged vad_out.
- SILENCE:
  - S, ONSET_FRAMES=1: go to SPEECH and pulse onset.
  - S, ONSET_FRAMES>1: go to ONSET_PEND with cnt=1.
  - N: stay.
- ONSET_PEND:
  - S: cnt+1; when cnt+1 == ONSET_FRAMES, go to SPEECH with cnt=0 and pulse onset.
  - N: go to SILENCE with cnt=0; no pulse.
- SPEECH:
  - S: stay.
  - N, HANG_FRAMES=0: go to SILENCE and pulse offset.
  - N, HANG_FRAMES>0: go to HANGOVER with cnt=1; if HANG_FRAMES=1, go to SILENCE instead and pulse offset.
- HANGOVER:
  - S: go to SPEECH with cnt=0; no onset pulse.
  - N: cnt+1; when cnt+1 == HANG_FRAMES, go to SILENCE with cnt=0 and pulse offset.
- speech_cnt: increments by 1 on each accepted frame whose post-update vad_out is 1, X frames included; holds at 2^STAT_W-1.
- flush:
  - Forces SILENCE, cnt=0 and vad_out=0 on the next cycle.
  - No pulses and no vad_valid; a simultaneous frame_valid is dropped.
  - speech_cnt is not cleared.
- frame_valid held high on back-to-back cycles: each cycle is a separate frame; no minimum spacing.
- Counters never exceed 2^CNT_W-1 under legal parameters; no wrap.

Test Plan:
1. Defaults; reset, then frames S,S,S → vad_valid after each frame; state_o 1,1,2; vad_out 0,0,1; onset_pulse only on the third update; speech_cnt=1.
2. In SPEECH; 7 N frames then 1 S → vad_out stays 1 throughout; state returns to 2; no offset_pulse or onset_pulse; speech_cnt +8.
3. In SPEECH; 8 N frames → vad_out drops to 0 on the 8th update with offset_pulse high that cycle only; state_o=0.
4. SILENCE; S,S,N,S,S,S → onset only after the final three S frames (ONSET_PEND aborted by the N); X frames interleaved anywhere leave the counter unchanged.
5. In HANGOVER with cnt=4; flush asserted together with frame_valid(S) → next cycle state_o=0, vad_out=0, vad_valid=0, no pulses; speech_cnt unchanged.
6. ONSET_FRAMES=1, HANG_FRAMES=0; alternate S,N for 4 frames → onset_pulse then offset_pulse alternating; speech_cnt=2. Separately, preload to 0xFFFE and run 3 speech frames → speech_cnt saturates at 0xFFFF.
